iq_frame_packer: RTL
====================

// Module: iq_frame_packer
// PURPOSE
//  Consumes the decimated I/Q pair from the two CIC decimators after the CORDIC
//  downconverter and buffers the pairs in a small FIFO. Serialises each pair into
//  a 6-byte framed stream on a valid/ready byte interface, for the UART/host link.
//  Decouples the CIC output rate from host back-pressure and flags sample loss.
// PARAMETERS
//  DATA_WIDTH   13     width of signed I and Q inputs (two's complement, <=16)
//  FIFO_AW      4      FIFO address width; depth = 2**FIFO_AW I/Q pairs
//  SYNC_BYTE    8'hA5  first byte of every frame
// PORTS
//  clk         in   1             single system clock (65 MHz domain)
//  arst_n      in   1             reset, asynchronous, active-low
//  i_data      in   DATA_WIDTH    decimated I sample (cos path)
//  q_data      in   DATA_WIDTH    decimated Q sample (sin path)
//  in_valid    in   1             CIC data_clk; a new pair is taken on each 0->1 edge
//  m_tdata     out  8             output byte
//  m_tvalid    out  1             m_tdata valid
//  m_tready    in   1             downstream accepts byte when m_tvalid & m_tready
//  m_tlast     out  1             high on the last byte (Q low) of a frame
//  ovf         out  1             sticky: a pair was dropped because the FIFO was full
//  ovf_clr     in   1             one-cycle pulse that clears ovf
//  fifo_level  out  FIFO_AW+1     number of pairs stored in the FIFO (0..2**FIFO_AW)
// BEHAVIOUR
//  Reset: all outputs 0. The FIFO is emptied, the sequence counter is 0, and the FSM is in IDLE.
//   Reset is asynchronous at any time, including mid-frame. It aborts the frame without
//   finishing it, and the partial frame is never completed.
//  Capture: in_valid is registered once (in_valid_d). push = in_valid & ~in_valid_d.
//   A level held high gives one push, and a 1-cycle pulse gives one push.
//   i_data and q_data are sampled in the same cycle that push is high.
//  FIFO: push is accepted if level < DEPTH, or if a pop happens in the same cycle.
//   Otherwise the pair is dropped and ovf is set. If set and ovf_clr are both high
//   in one cycle, set wins. Simultaneous push and pop leaves the level unchanged.
//   Pointers wrap modulo DEPTH.
//  Frame format (6 bytes, MSB first), with I and Q sign-extended to 16 bits:
//   SYNC_BYTE, SEQ[7:0], I[15:8], I[7:0], Q[15:8], Q[7:0]
//  FSM states: IDLE, SYNC, SEQ, IH, IL, QH, QL.
//   IDLE: if level != 0, pop into the hold register and go to SYNC. m_tvalid = 0.
//   SYNC..QL: m_tvalid = 1 and m_tdata is the byte for that state.
//    The FSM advances only on m_tvalid & m_tready.
//    While m_tready = 0, m_tdata and m_tlast hold stable. m_tvalid never drops mid-frame.
//   QL accepted: SEQ increments and wraps 255 -> 0.
//    If level != 0, pop and go to SYNC on the next cycle, with no idle bubble.
//    Otherwise go to IDLE.
//  m_tlast = 1 only in QL.
//  Latency: push in cycle N -> FIFO write at the end of N -> IDLE pops in N+1.
//   SYNC is driven with m_tvalid = 1 in N+2 (FSM idle, FIFO empty).
//  Outputs m_* and fifo_level are driven from registers (no combinational path from m_tready).
//  Throughput: one byte per clock at m_tready = 1. This far exceeds the CIC output rate (65 MHz/64).
// TESTING
//  1. Single pair: I = 13'h0123, Q = 13'h1FFF (-1), m_tready = 1
//     -> bytes A5,00,01,23,FF,FF; m_tlast only on the 6th byte; tvalid at push+2.
//  2. Back-pressure: toggle m_tready pseudo-randomly during a frame
//     -> byte order unchanged; m_tdata and m_tlast stable whenever tvalid & ~tready.
//  3. Overflow: m_tready = 0 and 18 in_valid edges
//     -> the FSM holds one pair; fifo_level reaches 16; the rest are dropped; ovf = 1.
//     After draining, exactly 17 frames are received, each with increasing SEQ.
//     ovf_clr -> ovf = 0.
//  4. SEQ wrap: 257 pairs -> SEQ bytes 0x00..0xFF, then 0x00 on frame 257.
//  5. Back-to-back: 3 pairs queued, m_tready = 1
//     -> 18 consecutive valid bytes with no m_tvalid gap.
//  6. Reset mid-frame: assert arst_n low during IH
//     -> m_tvalid = 0 immediately; fifo_level = 0, ovf = 0; the next frame starts with SYNC and SEQ = 0.

Source files
------------

// File: rtl/iq_frame_packer.sv
// I/Q pair packer: buffers decimated I/Q pairs in a small FIFO and serialises each
// pair into a 6-byte frame (SYNC, SEQ, IH, IL, QH, QL) on a valid/ready byte stream.
module iq_frame_packer #(
  parameter int          DATA_WIDTH = 13,
  parameter int          FIFO_AW    = 4,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [DATA_WIDTH-1:0] q_data,
  input  logic                  in_valid,
  output logic [7:0]            m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  ovf,
  input  logic                  ovf_clr,
  output logic [FIFO_AW:0]      fifo_level
);

  localparam int DEPTH = 2**FIFO_AW;
  localparam int PW    = 2*DATA_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_SEQ, S_IH, S_IL, S_QH, S_QL} state_t;

  logic                  r_in_valid_d;
  logic [PW-1:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0]    r_wr_ptr;
  logic [FIFO_AW-1:0]    r_rd_ptr;
  logic [FIFO_AW:0]      r_level;
  logic                  r_ovf;
  state_t                r_state;
  logic [7:0]            r_seq;
  logic [15:0]           r_hold_i;
  logic [15:0]           r_hold_q;
  logic [7:0]            r_tdata;
  logic                  r_tvalid;
  logic                  r_tlast;

  logic                  w_push;
  logic                  w_push_acc;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_adv;
  logic [PW-1:0]         w_rd_pair;
  logic signed [DATA_WIDTH-1:0] w_rd_i;
  logic signed [DATA_WIDTH-1:0] w_rd_q;

  assign w_push    = in_valid & ~r_in_valid_d;
  assign w_full    = (r_level == (FIFO_AW+1)'(DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_adv     = r_tvalid & m_tready;
  // Pop either from IDLE or straight out of an accepted QL so frames run back-to-back.
  assign w_pop     = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_QL) & w_adv));
  assign w_push_acc = w_push & (~w_full | w_pop);
  assign w_rd_pair = r_mem[r_rd_ptr];
  assign w_rd_i    = w_rd_pair[PW-1:DATA_WIDTH];
  assign w_rd_q    = w_rd_pair[DATA_WIDTH-1:0];

  assign m_tdata    = r_tdata;
  assign m_tvalid   = r_tvalid;
  assign m_tlast    = r_tlast;
  assign ovf        = r_ovf;
  assign fifo_level = r_level;

  always_ff @(posedge clk) begin
    if (w_push_acc) r_mem[r_wr_ptr] <= {i_data, q_data};
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_in_valid_d <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_in_valid_d <= in_valid;
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)      r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push_acc, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_push & ~w_push_acc) r_ovf <= 1'b1;
      else if (ovf_clr)         r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state  <= S_IDLE;
      r_seq    <= '0;
      r_hold_i <= '0;
      r_hold_q <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_hold_i <= 16'(w_rd_i);
            r_hold_q <= 16'(w_rd_q);
            r_state  <= S_SYNC;
            r_tdata  <= SYNC_BYTE;
            r_tvalid <= 1'b1;
          end
        end
        default: begin
          if (w_adv) begin
            unique case (r_state)
              S_SYNC: begin r_state <= S_SEQ; r_tdata <= r_seq;          end
              S_SEQ:  begin r_state <= S_IH;  r_tdata <= r_hold_i[15:8]; end
              S_IH:   begin r_state <= S_IL;  r_tdata <= r_hold_i[7:0];  end
              S_IL:   begin r_state <= S_QH;  r_tdata <= r_hold_q[15:8]; end
              S_QH:   begin
                r_state <= S_QL;
                r_tdata <= r_hold_q[7:0];
                r_tlast <= 1'b1;
              end
              default: begin
                r_seq   <= r_seq + 1'b1;
                r_tlast <= 1'b0;
                if (w_pop) begin
                  r_hold_i <= 16'(w_rd_i);
                  r_hold_q <= 16'(w_rd_q);
                  r_state  <= S_SYNC;
                  r_tdata  <= SYNC_BYTE;
                end else begin
                  r_state  <= S_IDLE;
                  r_tdata  <= '0;
                  r_tvalid <= 1'b0;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
